// File: rtl/line_buffer_3row.sv
// line_buffer_3row
//   Row-tap generator for 3x3 window stages. Accepts a raster-order pixel
//   stream and, one cycle after each accepted pixel, presents the pixels of
//   the same column from rows r-2, r-1 and r. Two lines are held in circular
//   line memories addressed by the column counter.
//
//   Optional feature (macro LINE_BUFFER_SOF_EN): adds an sof input that forces
//   the accompanying pixel to be treated as row 0, col 0.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   sof        start-of-frame marker, sampled with valid_in (LINE_BUFFER_SOF_EN only)
//   valid_in   din carries a pixel this cycle
//   din        raster-order pixel
//   valid_out  one-cycle pulse per output pixel triple
//   dout1      row r-2 pixel (top)
//   dout2      row r-1 pixel (centre)
//   dout3      row r pixel (bottom, current)
//   frame_done one-cycle pulse after the last pixel of a frame is accepted
module line_buffer_3row #(
    parameter int WIDTH      = 24,
    parameter int PIC_WIDTH  = 480,
    parameter int PIC_HEIGHT = 272
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef LINE_BUFFER_SOF_EN
    input  logic             sof,
`endif
    input  logic             valid_in,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             frame_done
);

    localparam int COL_W = $clog2(PIC_WIDTH);
    localparam int ROW_W = $clog2(PIC_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(PIC_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(PIC_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST_VALID = ROW_W'(2);

    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;

    // line_a holds row r-1, line_b holds row r-2
    logic [WIDTH-1:0] line_a [PIC_WIDTH];
    logic [WIDTH-1:0] line_b [PIC_WIDTH];

    // Position of the pixel currently on din (counters, or 0/0 on sof)
    logic [COL_W-1:0] eff_col;
    logic [ROW_W-1:0] eff_row;
    logic             col_last;
    logic             row_last;
    logic [WIDTH-1:0] a_old;
    logic [WIDTH-1:0] b_old;

    always_comb begin
        eff_col = col_cnt;
        eff_row = row_cnt;
`ifdef LINE_BUFFER_SOF_EN
        if (sof) begin
            eff_col = '0;
            eff_row = '0;
        end
`endif
        col_last = (eff_col == COL_LAST);
        row_last = (eff_row == ROW_LAST);
        a_old    = line_a[eff_col];
        b_old    = line_b[eff_col];
    end

    // Line memories: read-before-write, shift r-1 data down into the r-2 line
    always_ff @(posedge clk) begin
        if (valid_in) begin
            line_a[eff_col] <= din;
            line_b[eff_col] <= a_old;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            dout1      <= '0;
            dout2      <= '0;
            dout3      <= '0;
        end else if (valid_in) begin
            dout3      <= din;
            dout2      <= a_old;
            dout1      <= b_old;
            // rows 0 and 1 only prime the line memories
            valid_out  <= (eff_row >= ROW_FIRST_VALID);
            frame_done <= col_last && row_last;
            if (col_last) begin
                col_cnt <= '0;
                row_cnt <= row_last ? '0 : eff_row + ROW_W'(1);
            end else begin
                col_cnt <= eff_col + COL_W'(1);
                row_cnt <= eff_row;
            end
        end else begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_buffer_3row.sv
module tb_line_buffer_3row;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         sof;
    logic         valid_in;
    logic [W-1:0] din;
    logic         valid_out;
    logic [W-1:0] dout1;
    logic [W-1:0] dout2;
    logic [W-1:0] dout3;
    logic         frame_done;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [W-1:0] last_pix = '0;

    line_buffer_3row #(
        .WIDTH     (W),
        .PIC_WIDTH (4),
        .PIC_HEIGHT(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef LINE_BUFFER_SOF_EN
        .sof       (sof),
`endif
        .valid_in  (valid_in),
        .din       (din),
        .valid_out (valid_out),
        .dout1     (dout1),
        .dout2     (dout2),
        .dout3     (dout3),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Accept one pixel 0xRC and check the registered result one cycle later
    task automatic push(input logic [7:0] pix, input logic s);
        logic [3:0] r;
        logic       exp_valid;
        @(negedge clk);
        valid_in = 1'b1;
        din      = pix;
        sof      = s;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        sof      = 1'b0;
        r         = pix[7:4];
        exp_valid = (r >= 4'd2);
        check($sformatf("valid_out@%02h", pix), {31'd0, valid_out}, {31'd0, exp_valid});
        check($sformatf("frame_done@%02h", pix), {31'd0, frame_done}, {31'd0, pix == 8'h33});
        check($sformatf("dout3@%02h", pix), {24'd0, dout3}, {24'd0, pix});
        if (exp_valid) begin
            check($sformatf("dout1@%02h", pix), {24'd0, dout1}, {24'd0, pix - 8'h20});
            check($sformatf("dout2@%02h", pix), {24'd0, dout2}, {24'd0, pix - 8'h10});
        end
        last_pix = pix;
    endtask

    task automatic idle();
        @(negedge clk);
        valid_in = 1'b0;
        din      = 8'hEE;
        @(posedge clk);
        #1;
        check("gap_valid_out", {31'd0, valid_out}, 32'd0);
        check("gap_frame_done", {31'd0, frame_done}, 32'd0);
        check("gap_dout3_hold", {24'd0, dout3}, {24'd0, last_pix});
    endtask

    task automatic frame(input bit gaps);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (gaps) begin
                    int unsigned n;
                    n = $urandom_range(0, 1);
                    for (int k = 0; k < int'(n); k++) idle();
                end
                push({r[3:0], c[3:0]}, 1'b0);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        sof      = 1'b0;
        valid_in = 1'b0;
        din      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", {31'd0, valid_out}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_dout1", {24'd0, dout1}, 32'd0);
        check("rst_dout2", {24'd0, dout2}, 32'd0);
        check("rst_dout3", {24'd0, dout3}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // continuous frames, second one must re-prime
        frame(1'b0);
        frame(1'b0);
        // gapped frame
        frame(1'b1);

        // partial line then asynchronous reset between edges
        for (int p = 0; p < 7; p++) begin
            logic [7:0] pix;
            pix = (p < 4) ? 8'(p) : 8'(8'h10 + p - 4);
            push(pix, 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_dout3", {24'd0, dout3}, 32'd0);
        check("async_rst_dout2", {24'd0, dout2}, 32'd0);
        check("async_rst_dout1", {24'd0, dout1}, 32'd0);
        check("async_rst_valid", {31'd0, valid_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_pix = '0;
        frame(1'b0);

`ifdef LINE_BUFFER_SOF_EN
        // partial frame of 6 pixels, then restart with sof
        for (int p = 0; p < 6; p++) begin
            logic [7:0] pix;
            pix = (p < 4) ? 8'(p) : 8'(8'h10 + p - 4);
            push(pix, 1'b0);
        end
        push(8'h00, 1'b1);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (r != 0 || c != 0) push({r[3:0], c[3:0]}, 1'b0);
            end
        end
`endif

        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
